// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: state encodings and default width.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 8;

  // S_ZERO is only entered when the divide-by-zero fast path is compiled in.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ZERO = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtraction for one restoring-division step: {0,B} is subtracted from the
// WIDTH+1-bit partial remainder t. Purely combinational.
module div_trial_sub
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   t,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0] full_diff;

  // A set top bit means t < d, so the step must restore.
  always_comb begin
    full_diff = t - {1'b0, d};
    diff      = full_diff[WIDTH-1:0];
    borrow    = full_diff[WIDTH];
  end

endmodule

// File: rtl/restoring_divider_8bit.sv
// Sequential unsigned restoring divider, one trial subtraction per clock.
// Optional feature macro: DIV_BYZERO_FAST_EN (divisor 0 skips the iteration).
//
//   state  | meaning
//   S_IDLE | waiting for start; results hold
//   S_RUN  | iterating, one quotient bit per edge
//   S_DONE | results valid, done pulses; start here is accepted
//   S_ZERO | divide-by-zero shortcut, one cycle (fast path only)
module restoring_divider_8bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] q_sh_q, q_sh_d;
  logic [WIDTH-1:0] r_acc_q, r_acc_d;
  logic [WIDTH-1:0] d_reg_q, d_reg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             last_step;
  logic [WIDTH:0]   trial_t;
  logic [WIDTH-1:0] trial_diff;
  logic             trial_borrow;
  logic [WIDTH-1:0] q_sh_step;
  logic [WIDTH-1:0] r_acc_step;

  assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_step = (state_q == S_RUN) && (cnt_q == CNT_W'(WIDTH - 1));
  assign trial_t   = {r_acc_q, q_sh_q[WIDTH-1]};

  div_trial_sub #(.WIDTH(WIDTH)) u_trial (
    .t      (trial_t),
    .d      (d_reg_q),
    .diff   (trial_diff),
    .borrow (trial_borrow)
  );

  // Next shift-register contents for one step: keep the difference unless it borrowed.
  always_comb begin
    q_sh_step  = {q_sh_q[WIDTH-2:0], ~trial_borrow};
    r_acc_step = trial_borrow ? trial_t[WIDTH-1:0] : trial_diff;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
`ifdef DIV_BYZERO_FAST_EN
          state_d = (divisor == '0) ? S_ZERO : S_RUN;
`else
          state_d = S_RUN;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN:   if (last_step) state_d = S_DONE;
      S_ZERO:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // Datapath next values: operand capture, iteration, and result load.
  always_comb begin
    q_sh_d      = q_sh_q;
    r_acc_d     = r_acc_q;
    d_reg_d     = d_reg_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    if (accept) begin
      q_sh_d  = dividend;
      d_reg_d = divisor;
      r_acc_d = '0;
      cnt_d   = '0;
    end else if (state_q == S_RUN) begin
      q_sh_d  = q_sh_step;
      r_acc_d = r_acc_step;
      cnt_d   = cnt_q + CNT_W'(1);
      if (last_step) begin
        quotient_d  = q_sh_step;
        remainder_d = r_acc_step;
        dbz_d       = (d_reg_q == '0);
      end
    end
`ifdef DIV_BYZERO_FAST_EN
    else if (state_q == S_ZERO) begin
      quotient_d  = '1;
      remainder_d = q_sh_q;
      dbz_d       = 1'b1;
    end
`endif
  end

  // Datapath and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_sh_q      <= '0;
      r_acc_q     <= '0;
      d_reg_q     <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      q_sh_q      <= q_sh_d;
      r_acc_q     <= r_acc_d;
      d_reg_q     <= d_reg_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
